// File: rtl/dct2d_stream.sv
`default_nettype none
// ============================================================================
// Module   : dct2d_stream
// Purpose  : Streaming 8x8 two-dimensional orthonormal DCT-II. Accepts 64
//            pixels in raster order, runs eight row transforms and eight
//            column transforms through one shared 8-point engine, then
//            streams the 64 coefficients X(u,v) out in index order 8*u+v.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-low reset
//   in_valid   in   1      in_data holds a sample
//   in_ready   out  1      block accepts a sample this cycle (LOAD only)
//   in_data    in   IN_W   unsigned pixel, raster order
//   out_valid  out  1      out_data holds a coefficient
//   out_ready  in   1      sink accepts the coefficient this cycle
//   out_data   out  OUT_W  signed coefficient, index 8*u+v
//   out_last   out  1      marks coefficient 63 of a block
//   busy       out  1      block is transforming or draining
//   sat_flag   out  1      sticky: a coefficient of this block was clipped
// ============================================================================
module dct2d_stream #(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 16,
    parameter int FRAC_W      = 12,   // supported range 1..29
    parameter int LEVEL_SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             sat_flag
);

    // Stored values carry FRAC_W fractional bits (integers after LOAD).
    localparam int DATA_W = IN_W + FRAC_W + 8;
    // Products of a stored value and a constant plus an 8-term sum.
    localparam int ACC_W  = DATA_W + FRAC_W + 4;
    // Cosine constants: +2^FRAC_W must be representable as signed.
    localparam int CW     = FRAC_W + 2;

    localparam logic signed [DATA_W-1:0] SHIFT_OFS =
        DATA_W'((LEVEL_SHIFT != 0) ? (64'sd1 <<< (IN_W - 1)) : 64'sd0);
    localparam logic signed [DATA_W-1:0] RND_OFS = DATA_W'(64'sd1 <<< (FRAC_W - 1));
    localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-(64'sd1 <<< (OUT_W - 1)));

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROW   = 2'd1,
        ST_COL   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // round(cos(j*pi/16) * 2^FRAC_W), derived from 30-bit-fraction values so
    // FRAC_W stays a free parameter. j = 0 and j = 8 are exact.
    function automatic logic signed [CW-1:0] cos_c(input int j);
        logic [63:0] c30;
        case (j)
            1:       c30 = 64'd1053110176;
            2:       c30 = 64'd992008094;
            3:       c30 = 64'd892783698;
            4:       c30 = 64'd759250125;
            5:       c30 = 64'd596538995;
            6:       c30 = 64'd410903207;
            7:       c30 = 64'd209476638;
            default: c30 = 64'd0;
        endcase
        if (j == 0) begin
            return CW'(64'd1 << FRAC_W);
        end
        return CW'((c30 + (64'd1 << (29 - FRAC_W))) >> (30 - FRAC_W));
    endfunction

    // Basis entry C(k)*cos((2n+1)k*pi/16). The DC row uses the cos(pi/4)
    // constant, which is exactly C(0)=1/sqrt2. The common 1/2 factor is
    // applied as an extra shift after accumulation.
    function automatic logic signed [CW-1:0] dct_coef(input int k, input int n);
        int m;
        if (k == 0) begin
            m = 4;
        end else begin
            m = ((2 * n + 1) * k) % 32;
            if (m > 16) begin
                m = 32 - m;
            end
        end
        if (m <= 8) begin
            return cos_c(m);
        end
        return -cos_c(16 - m);
    endfunction

    state_t              state_q;
    logic [5:0]          cnt_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [OUT_W-1:0]    out_data_q;
    logic                out_last_q;
    logic                busy_q;
    logic                sat_q;

    // buf_a: samples, then final coefficients. buf_b: transposed row results.
    // Two buffers are needed because a transposed write of row r lands on
    // column r, which still holds unread samples of later rows.
    logic signed [DATA_W-1:0] buf_a_q [64];
    logic signed [DATA_W-1:0] buf_b_q [64];

    logic                      in_hs;
    logic signed [DATA_W-1:0]  sample_d;
    logic signed [DATA_W-1:0]  eng_in  [8];
    logic signed [ACC_W-1:0]   acc     [8];
    logic signed [DATA_W-1:0]  eng_out [8];
    logic [5:0]                drain_idx;
    logic signed [DATA_W-1:0]  coef_rnd;
    logic [OUT_W-1:0]          coef_d;
    logic                      clip_d;
    logic                      last_d;

    assign in_hs    = in_valid && in_ready_q;
    assign sample_d = DATA_W'($signed({1'b0, in_data})) - SHIFT_OFS;

    // Shared 1D engine: row r of buf_a during ROW, row r of buf_b during COL.
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            if (state_q == ST_COL) begin
                eng_in[n] = buf_b_q[{cnt_q[2:0], 3'(n)}];
            end else begin
                eng_in[n] = buf_a_q[{cnt_q[2:0], 3'(n)}];
            end
        end
    end

    // Row inputs are integers, so one extra shift (the 1/2) leaves FRAC_W
    // fractional bits; column inputs already carry FRAC_W, so drop those too.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            acc[k] = '0;
            for (int n = 0; n < 8; n++) begin
                acc[k] = acc[k] + ACC_W'(eng_in[n]) * ACC_W'(dct_coef(k, n));
            end
            if (state_q == ST_COL) begin
                eng_out[k] = DATA_W'(acc[k] >>> (FRAC_W + 1));
            end else begin
                eng_out[k] = DATA_W'(acc[k] >>> 1);
            end
        end
    end

    // The output register is loaded with the coefficient it will show next:
    // the current index when priming, the following index after a handshake.
    assign drain_idx = out_valid_q ? (cnt_q + 6'd1) : cnt_q;
    assign last_d    = (drain_idx == 6'd63);

    always_comb begin
        coef_rnd = (buf_a_q[drain_idx] + RND_OFS) >>> FRAC_W;
        clip_d   = 1'b0;
        coef_d   = OUT_W'(coef_rnd);
        if (coef_rnd > SAT_MAX) begin
            coef_d = OUT_W'(SAT_MAX);
            clip_d = 1'b1;
        end else if (coef_rnd < SAT_MIN) begin
            coef_d = OUT_W'(SAT_MIN);
            clip_d = 1'b1;
        end
    end

    // Buffer storage has no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        case (state_q)
            ST_LOAD: begin
                if (in_hs) begin
                    buf_a_q[cnt_q] <= sample_d;
                end
            end
            ST_ROW: begin
                for (int k = 0; k < 8; k++) begin
                    buf_b_q[{3'(k), cnt_q[2:0]}] <= eng_out[k];
                end
            end
            ST_COL: begin
                for (int k = 0; k < 8; k++) begin
                    buf_a_q[{3'(k), cnt_q[2:0]}] <= eng_out[k];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (in_hs) begin
                        if (cnt_q == 6'd0) begin
                            sat_q <= 1'b0;
                        end
                        if (cnt_q == 6'd63) begin
                            state_q    <= ST_ROW;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                ST_ROW: begin
                    if (cnt_q[2:0] == 3'd7) begin
                        state_q <= ST_COL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                ST_COL: begin
                    if (cnt_q[2:0] == 3'd7) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= coef_d;
                        out_last_q  <= last_d;
                        sat_q       <= sat_q | clip_d;
                    end else if (out_ready) begin
                        if (cnt_q == 6'd63) begin
                            state_q     <= ST_LOAD;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q + 6'd1;
                            out_data_q <= coef_d;
                            out_last_q <= last_d;
                            sat_q      <= sat_q | clip_d;
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign sat_flag  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dct2d_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct2d_stream
// Purpose  : Self-checking bench for dct2d_stream. A double-precision DCT
//            model fills a scoreboard when each block is driven; monitors pop
//            and compare every output beat. A second instance with OUT_W=8
//            covers saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_dct2d_stream;

    localparam int IN_W = 8;
    typedef int blk_t [64];

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready = 1'b0, out_last, busy, sat_flag;
    logic [IN_W-1:0] in_data;
    logic [15:0] out_data;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy, s_sat_flag;
    logic [IN_W-1:0] s_in_data;
    logic [7:0]  s_out_data;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];
    int   q2[$];
    int   beats = 0;
    int   beats2 = 0;
    int   got[64];
    int   got2[64];
    int   rdy_mode = 1;
    logic stall_q = 1'b0;
    int   prev_data;
    logic prev_last;
    logic sat_after_first;
    real  ctab[8][8];

    always #5 clk = ~clk;

    dct2d_stream dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .sat_flag(sat_flag)
    );

    dct2d_stream #(.OUT_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy), .sat_flag(s_sat_flag)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp);
        int d;
        n_cmp++;
        d = obs - exp;
        assert ((d >= -1 && d <= 1) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (+/-1)", tag, obs, exp);
        end
    endtask

    task automatic timeout_abort(input string tag);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: observed timeout expected DUT event", tag);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // Double-precision orthonormal 2D DCT, rounded and clipped to ow bits.
    function automatic void model(input blk_t pix, input int ow, output blk_t coef);
        real s, cu, cv;
        int  r, mx;
        mx = (1 << (ow - 1)) - 1;
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                s = 0.0;
                for (int y = 0; y < 8; y++) begin
                    for (int x = 0; x < 8; x++) begin
                        s = s + real'(pix[8*y+x] - 128) * ctab[u][y] * ctab[v][x];
                    end
                end
                cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                s  = 0.25 * cu * cv * s;
                r  = $rtoi($floor(s + 0.5));
                if (r > mx) r = mx;
                if (r < -mx - 1) r = -mx - 1;
                coef[8*u+v] = r;
            end
        end
    endfunction

    // Output pacing for the main instance; mode 3 stops accepting at beat 30.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(1));
            default: out_ready = (beats < 30);
        endcase
    end

    // Main monitor: hold-stability during stalls, then scoreboard compare.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && stall_q) begin
                check("hold_data", int'($signed(out_data)), prev_data);
                check("hold_last", int'(out_last), int'(prev_last));
            end
            stall_q   = out_valid && !out_ready;
            prev_data = int'($signed(out_data));
            prev_last = out_last;
            if (out_valid && out_ready) begin
                check("sb_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check_tol("coef", int'($signed(out_data)), exp_q.pop_front());
                end
                check("out_last", int'(out_last), int'(beats == 63));
                got[beats] = int'($signed(out_data));
                beats = (beats == 63) ? 0 : beats + 1;
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset && s_out_valid && s_out_ready) begin
            check("sb8_nonempty", int'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
                check_tol("coef8", int'($signed(s_out_data)), q2.pop_front());
            end
            check("out_last8", int'(s_out_last), int'(beats2 == 63));
            got2[beats2] = int'($signed(s_out_data));
            beats2 = (beats2 == 63) ? 0 : beats2 + 1;
        end
    end

    task automatic drive(input int which, input logic v, input int d);
        if (which == 1) begin
            s_in_valid = v;
            s_in_data  = IN_W'(d);
        end else begin
            in_valid = v;
            in_data  = IN_W'(d);
        end
    endtask

    task automatic send(input int which, input blk_t pix, input int gap_pct);
        blk_t e;
        int   t;
        model(pix, (which == 1) ? 8 : 16, e);
        for (int i = 0; i < 64; i++) begin
            if (which == 1) q2.push_back(e[i]);
            else            exp_q.push_back(e[i]);
        end
        for (int i = 0; i < 64; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                drive(which, 1'b0, 0);
                @(posedge clk); #1;
            end
            drive(which, 1'b1, pix[i]);
            t = 0;
            forever begin
                @(negedge clk);
                if (((which == 1) ? s_in_ready : in_ready) == 1'b1) break;
                t++;
                if (t > 4000) timeout_abort("in_ready_wait");
            end
            @(posedge clk); #1;
            if (which == 1 && i == 0) sat_after_first = s_sat_flag;
        end
        drive(which, 1'b0, 0);
    endtask

    task automatic wait_drain(input int which);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (which == 1 && q2.size() == 0 && beats2 == 0) break;
            if (which == 0 && exp_q.size() == 0 && beats == 0) break;
            t++;
            if (t > 6000) timeout_abort("drain_wait");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        blk_t b128, b255, bimp, brnd;
        int   n, t;

        for (int u = 0; u < 8; u++)
            for (int y = 0; y < 8; y++)
                ctab[u][y] = $cos(real'((2 * y + 1) * u) * 3.14159265358979323846 / 16.0);
        for (int i = 0; i < 64; i++) begin
            b128[i] = 128;
            b255[i] = 255;
            bimp[i] = (i == 0) ? 255 : 128;
        end

        reset = 1'b0;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        s_out_ready = 1'b1;
        rdy_mode = 1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        check("rst_in_ready", int'(in_ready), 0);

        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_in_ready8", int'(s_in_ready), 1);

        // Flat mid-grey block: all zero coefficients
        send(0, b128, 0);
        wait_drain(0);
        check("flat_x00", got[0], 0);
        check("flat_sat", int'(sat_flag), 0);
        check("flat_busy", int'(busy), 0);
        check("flat_in_ready", int'(in_ready), 1);

        // Full white block, with latency measurement
        send(0, b255, 0);
        check("row_in_ready", int'(in_ready), 0);
        check("row_busy", int'(busy), 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
        check("latency", n, 17);
        wait_drain(0);
        check_tol("white_x00", got[0], 1016);
        check_tol("white_x01", got[1], 0);
        check_tol("white_x77", got[63], 0);
        check("white_sat", int'(sat_flag), 0);

        // Single bright pixel with random back-pressure
        rdy_mode = 2;
        send(0, bimp, 10);
        wait_drain(0);
        check_tol("imp_x00", got[0], 16);
        check_tol("imp_x01", got[1], 22);
        check_tol("imp_x10", got[8], 22);

        // Saturation on the 8-bit-output instance
        send(1, b255, 0);
        wait_drain(1);
        check("sat_x00", got2[0], 127);
        check("sat_flag_set", int'(s_sat_flag), 1);
        send(1, b128, 0);
        check("sat_clear_first_hs", int'(sat_after_first), 0);
        wait_drain(1);
        check("sat_flag_next", int'(s_sat_flag), 0);

        // Random blocks, random gaps, random out_ready
        for (int blk = 0; blk < 100; blk++) begin
            for (int i = 0; i < 64; i++) brnd[i] = int'($urandom_range(255));
            send(0, brnd, 25);
        end
        wait_drain(0);

        // Reset while stalled mid-drain
        rdy_mode = 3;
        for (int i = 0; i < 64; i++) brnd[i] = int'($urandom_range(255));
        send(0, brnd, 0);
        t = 0;
        while (beats != 30) begin
            @(negedge clk);
            t++;
            if (t > 3000) timeout_abort("beat30_wait");
        end
        repeat (3) @(negedge clk);
        check("stall_valid", int'(out_valid), 1);
        check("stall_ready", int'(out_ready), 0);
        #2 reset = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        exp_q.delete();
        beats = 0;
        rdy_mode = 1;
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("abort_rel_in_ready", int'(in_ready), 1);
        check("abort_rel_out_valid", int'(out_valid), 0);
        rdy_mode = 2;
        for (int i = 0; i < 64; i++) brnd[i] = int'($urandom_range(255));
        send(0, brnd, 10);
        wait_drain(0);

        check("sb_empty", exp_q.size(), 0);
        check("sb8_empty", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dct2d_stream.md
DCT2D_STREAM -- requirements
Module: dct2d_stream

Interface
REQ-001 Parameter IN_W, default 8: input sample width (unsigned pixel).
REQ-002 Parameter OUT_W, default 16: output coefficient width (signed two's complement).
REQ-003 Parameter FRAC_W, default 12: fractional bits of cosine constants and of internal datapath.
REQ-004 Parameter LEVEL_SHIFT, default 1: 1 subtracts 2^(IN_W-1) from each sample on entry; 0 passes the sample through unsigned.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  in_data holds a sample.
REQ-008 in_ready  out  1  block accepts a sample this cycle.
REQ-009 in_data  in  IN_W  pixel, raster order, index 8*y+x.
REQ-010 out_valid  out  1  out_data holds a coefficient.
REQ-011 out_ready  in  1  sink accepts the coefficient this cycle.
REQ-012 out_data  out  OUT_W  coefficient X(u,v), index 8*u+v (u vertical frequency).
REQ-013 out_last  out  1  marks coefficient 63 of a block.
REQ-014 busy  out  1  high in ROW, COL or DRAIN.
REQ-015 sat_flag  out  1  sticky: at least one coefficient of the current block saturated.

Function
REQ-016 FSM states: LOAD, ROW, COL, DRAIN; an input handshake is in_valid&&in_ready; an output handshake is out_valid&&out_ready.
REQ-017 LOAD: in_ready=1; each input handshake writes to buffer[cnt]; cnt increments 0..63; the handshake at cnt=63 moves to ROW; in_valid=0 stalls with no state change.
REQ-018 ROW: 8 cycles; cycle r applies the 8-point 1D DCT to row r, writing results transposed (element k to position 8*k+r); then COL.
REQ-019 COL: 8 cycles, same 1D engine on the transposed rows, writing transposed back so the buffer holds X(u,v) at 8*u+v; then DRAIN.
REQ-020 Latency: the 64th input handshake at edge T gives out_valid=1 after edge T+17.
REQ-021 DRAIN: out_valid=1; out_data=coefficient[cnt]; cnt advances only on output handshake; out_last=1 only at cnt=63.
REQ-022 While out_valid&&!out_ready, out_data and out_last are held stable.
REQ-023 The handshake at cnt=63 returns to LOAD with cnt=0; in_ready=1 on the following cycle, with no dead cycle beyond that.
REQ-024 in_ready=0 in ROW, COL and DRAIN; in_valid in those states is ignored with no sample consumed.
REQ-025 Transform is orthonormal: X(u,v)=1/4 C(u)C(v) sum x(y,x) cos((2y+1)u*pi/16) cos((2x+1)v*pi/16), C(0)=1/sqrt2, else 1.
REQ-026 Cosine constants: round(cos(k*pi/16)*2^FRAC_W), k=1..7; 1/sqrt2 is folded into the k=4 constant.
REQ-027 Internal width is IN_W+FRAC_W+8 bits signed; no intermediate overflow for any input.
REQ-028 Final rounding adds 2^(FRAC_W-1), then arithmetic right shift by FRAC_W.
REQ-029 The rounded result saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any clip sets sat_flag.
REQ-030 sat_flag clears on the first input handshake of a new block.
REQ-031 Accuracy: every coefficient is within ±1 LSB of a double-precision reference, for FRAC_W>=12.

Reset
REQ-032 Reset asserted: state=LOAD, cnt=0, out_valid=0, out_data=0, out_last=0, busy=0, sat_flag=0, in_ready=0.
REQ-033 First cycle after reset release: in_ready=1; buffer contents are not reset and are never observable before being written.
REQ-034 Reset in any state, including mid-DRAIN with output stalled, aborts the block; the partially drained block is never resumed.

Verification
REQ-035 All samples 128, LEVEL_SHIFT=1 -> 64 outputs, all 0; out_last only on beat 64; sat_flag=0.
REQ-036 All samples 255 -> X(0,0)=1016, other 63 coefficients 0 (±1); out_valid rises exactly 17 cycles after the last input handshake.
REQ-037 Sample 0 = 255, rest 128 -> X(0,0)=16, X(0,1)=X(1,0)=22 (±1); full block matches the reference model within ±1.
REQ-038 Random out_ready (50%) plus random in_valid gaps over 100 random blocks -> order preserved, data stable during stalls, no lost or duplicated beat.
REQ-039 OUT_W=8, all samples 255 -> X(0,0)=127, sat_flag=1; next block of all 128 -> sat_flag=0 after its first input handshake.
REQ-040 Reset pulse at DRAIN beat 30 with out_ready=0 -> out_valid=0 immediately; after release in_ready=1; next full block is correct.
